// File: rtl/lsu_byte_sequencer.sv
// Purpose : turns one 32-bit CPU load/store into 1, 2 or 4 consecutive byte accesses on the dram.
// Latency : N+1 cycles from REQ acceptance to the DONE pulse (N = 1/2/4 bytes); issue interval N+2.
// Backpressure: none queued; REQ is only sampled in IDLE, requests arriving while busy are dropped.
//
// Ports:
//   CLK, RST_N        clock and asynchronous active-low reset
//   REQ/WE/SIZE/UNSIGNED/ADDR/WDATA   request from execute, latched on acceptance
//   RDATA/BUSY/DONE/ERR               result and handshake back to execute
//   DRAM_ADDR/DRAM_DATA_SEL/DRAM_DATA_WRITE/DRAM_MW   byte-mode drive of the dram
//   DRAM_DATA_IN      combinational read data for DRAM_ADDR
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   -> misaligned half/word requests skip the dram and complete with ERR
//   undefined -> ERR is tied low and misaligned requests are sequenced bytewise
module lsu_byte_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ,
  input  logic              WE,
  input  logic [1:0]        SIZE,
  input  logic              UNSIGNED,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W-1:0] DRAM_ADDR,
  output logic [1:0]        DRAM_DATA_SEL,
  output logic [7:0]        DRAM_DATA_WRITE,
  output logic              DRAM_MW,
  input  logic [7:0]        DRAM_DATA_IN
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;

  // Request fields captured at acceptance so the dram side only sees registered values.
  logic                we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [DATA_W-1:0]   rbuf_q;     // bytes gathered so far for the current load
  logic [DATA_W-1:0]   rdata_q;    // last completed load result
  logic [DATA_W-1:0]   assembled;  // rbuf_q with the byte arriving this cycle merged in
  logic [DATA_W-1:0]   extended;   // assembled value after sign/zero extension

  logic [1:0]          last_idx;   // index of the final byte for the latched size
  logic                accept;
  logic                trap_req;   // incoming request completes immediately with ERR

  logic                busy_c;
  logic                done_c;
  logic                mw_c;
  logic [ADDR_W-1:0]   dram_addr_c;
  logic [7:0]          dram_wr_c;

  assign accept = (state_q == ST_IDLE) && REQ;

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  always_comb begin
    trap_req = 1'b0;
    case (SIZE)
      2'b00:   trap_req = 1'b0;
      2'b01:   trap_req = ADDR[0];
      default: trap_req = (ADDR[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= trap_req;
    end
  end

  assign ERR = (state_q == ST_DONE) && err_q;
`else
  assign trap_req = 1'b0;
  assign ERR      = 1'b0;
`endif

  // Byte count minus one; size 11 behaves as a word.
  always_comb begin
    last_idx = 2'd3;
    case (size_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    mw_c        = 1'b0;
    dram_addr_c = '0;
    dram_wr_c   = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          idx_d   = 2'd0;
          state_d = trap_req ? ST_DONE : ST_XFER;
        end
      end
      ST_XFER: begin
        busy_c      = 1'b1;
        mw_c        = we_q;
        // Natural ADDR_W-bit overflow gives the silent wrap at the top of memory.
        dram_addr_c = addr_q + ADDR_W'(idx_q);
        if (we_q) begin
          dram_wr_c = wdata_q[{idx_q, 3'b000} +: 8];
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == last_idx) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Load assembly (little-endian) and extension
  // ------------------------------------------------------------------
  always_comb begin
    assembled                         = rbuf_q;
    assembled[{idx_q, 3'b000} +: 8]   = DRAM_DATA_IN;
  end

  // Upper bytes of rbuf_q may be stale from an earlier load; extension
  // overwrites everything above the transferred width, so no clear is needed.
  always_comb begin
    extended = assembled;
    case (size_q)
      2'b00:   extended = {{(DATA_W-8){~uns_q & assembled[7]}}, assembled[7:0]};
      2'b01:   extended = {{(DATA_W-16){~uns_q & assembled[15]}}, assembled[15:0]};
      default: extended = assembled;
    endcase
  end

  // ------------------------------------------------------------------
  // Request latch and load result registers
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= WE;
        size_q  <= SIZE;
        uns_q   <= UNSIGNED;
        addr_q  <= ADDR;
        wdata_q <= WDATA;
      end
      if ((state_q == ST_XFER) && !we_q) begin
        rbuf_q <= assembled;
        if (idx_q == last_idx) begin
          rdata_q <= extended;
        end
      end
    end
  end

  // All dram-facing outputs come from registered state, so reset removes
  // DRAM_MW immediately without waiting for a clock edge.
  assign RDATA           = rdata_q;
  assign BUSY            = busy_c;
  assign DONE            = done_c;
  assign DRAM_ADDR       = dram_addr_c;
  assign DRAM_DATA_SEL   = 2'b10;
  assign DRAM_DATA_WRITE = dram_wr_c;
  assign DRAM_MW         = mw_c;

endmodule
